mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16, memory address width in bits.
REQ-002 Parameter NUM_CH, default 2, requester channel count (1..8).
REQ-003 Parameter BYTES, default 4, bytes per requester word (1..8); byte count fixed per access.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  NUM_CH  per-channel request pending.
REQ-007 req_write  in  NUM_CH  per-channel request type: 1 = write, 0 = read.
REQ-008 req_addr  in  NUM_CH*ADDR_W  per-channel base byte address; channel i at [i*ADDR_W +: ADDR_W].
REQ-009 req_wdata  in  NUM_CH*8*BYTES  per-channel write word, little-endian byte order.
REQ-010 req_ready  out  NUM_CH  one-cycle pulse: request accepted, inputs latched.
REQ-011 rsp_valid  out  NUM_CH  one-cycle pulse: access of that channel complete.
REQ-012 rsp_rdata  out  8*BYTES  assembled read word, shared by all channels.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 mem_address  out  ADDR_W  byte address to memory.
REQ-015 mem_read / mem_write  out  1 each  access strobes; never both high.
REQ-016 mem_write_value  out  8  write byte.
REQ-017 mem_read_value  in  8  read byte, valid in the cycle mem_ready is high.
REQ-018 mem_ready  in  1  memory completes the current strobed access this cycle.

Function
REQ-019 FSM states: IDLE, ACCESS, DONE.
REQ-020 IDLE: if any req_valid, grant one channel round-robin, starting the search at priority pointer ptr; pulse req_ready[grant]; latch addr, wdata, write and grant index; clear byte_cnt; go to ACCESS.
REQ-021 IDLE with no req_valid: stay; all outputs idle.
REQ-022 ACCESS: mem_address = latched addr + byte_cnt, modulo 2^ADDR_W (wraps from all-ones to 0); mem_read = !write; mem_write = write; mem_write_value = wdata byte byte_cnt.
REQ-023 Strobes and address stay stable until mem_ready; arbitrary wait cycles allowed.
REQ-024 ACCESS with mem_ready: on reads, capture mem_read_value into rsp_rdata[byte_cnt*8 +: 8]; byte_cnt increments; after byte BYTES-1, go to DONE.
REQ-025 mem_ready is ignored outside ACCESS.
REQ-026 DONE: pulse rsp_valid[grant] for one cycle; set ptr = (grant+1) mod NUM_CH; go to IDLE.
REQ-027 Strobes are low in IDLE and DONE, so consecutive requests have at least one idle memory cycle between them.
REQ-028 Latency with mem_ready held high: req_ready in cycle 0; bytes in cycles 1..BYTES; rsp_valid in cycle BYTES+1; next accept no earlier than cycle BYTES+2.
REQ-029 rsp_rdata is valid from the rsp_valid of a read until the next read begins capturing; write accesses leave rsp_rdata unchanged.
REQ-030 A requester holds req_valid and its inputs until req_ready; deasserting earlier withdraws the request without side effects.
REQ-031 Requester inputs are not sampled after acceptance; changes during ACCESS have no effect.
REQ-032 Accepted requests always run to completion; there is no abort except reset.

Reset
REQ-033 rst_n low immediately forces: state IDLE, ptr 0, byte_cnt 0, rsp_rdata 0, and all outputs 0.
REQ-034 Reset during ACCESS abandons the access; no rsp_valid is produced for it.
REQ-035 After rst_n rises, the first accept occurs no earlier than the first clock edge.

Verification
REQ-036 BYTES=4; ch0 reads addr 0x0100, memory returns 11,22,33,44 with ready always high -> addresses 0x100..0x103 on cycles 1-4; rsp_valid[0] on cycle 5; rsp_rdata 0x44332211.
REQ-037 ch1 writes 0xA1B2C3D4 to 0x0200 with ready low 2 cycles per byte -> mem_write_value sequence D4,C3,B2,A1, each held 3 cycles at a stable address; rsp_valid[1] once.
REQ-038 Both channels hold req_valid continuously -> grants alternate 0,1,0,1 starting with 0 after reset.
REQ-039 Read at 0xFFFE with ADDR_W=16 -> addresses FFFE, FFFF, 0000, 0001.
REQ-040 rst_n low at the 2nd byte of a read -> strobes drop immediately, no rsp_valid; the next request after reset is granted to ch0 and completes normally.
REQ-041 req_valid[0] pulsed for 1 cycle while ch1's access is in progress -> ch0 is never granted; no spurious rsp_valid[0].

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Multi-channel byte-serial memory access controller.
// Grants one requester at a time (round-robin), then walks the memory one byte per
// completed handshake, assembling read words little-endian.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned BYTES  = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_CH-1:0]          i_req_valid,
    input  logic [NUM_CH-1:0]          i_req_write,
    input  logic [NUM_CH*ADDR_W-1:0]   i_req_addr,
    input  logic [NUM_CH*8*BYTES-1:0]  i_req_wdata,
    output logic [NUM_CH-1:0]          o_req_ready,
    output logic [NUM_CH-1:0]          o_rsp_valid,
    output logic [8*BYTES-1:0]         o_rsp_rdata,
    output logic                       o_busy,
    output logic [ADDR_W-1:0]          o_mem_address,
    output logic                       o_mem_read,
    output logic                       o_mem_write,
    output logic [7:0]                 o_mem_write_value,
    input  logic [7:0]                 i_mem_read_value,
    input  logic                       i_mem_ready
);

    localparam int unsigned PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned DATA_W = 8 * BYTES;

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    r_grant;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_write;
    logic [CNT_W-1:0]    r_byte_cnt;
    logic [DATA_W-1:0]   r_rdata;

    logic [2*NUM_CH-1:0] w_valid_dbl;
    logic [NUM_CH-1:0]   w_valid_rot;
    logic                w_grant_found;
    logic [PTR_W-1:0]    w_grant_idx;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_sel_write;
    logic [7:0]          w_wbyte;
    logic [DATA_W-1:0]   w_rdata_next;
    logic                w_accept;
    logic                w_last_byte;

    // Rotate the request vector so bit 0 is the channel at the priority pointer.
    assign w_valid_dbl = {i_req_valid, i_req_valid} >> r_ptr;
    assign w_valid_rot = w_valid_dbl[NUM_CH-1:0];
    assign w_last_byte = (r_byte_cnt == CNT_W'(BYTES - 1));
    assign o_rsp_rdata = r_rdata;

    // Pick the first pending channel at or after the priority pointer.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!w_grant_found && w_valid_rot[i]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = PTR_W'((32'(r_ptr) + i) % NUM_CH);
            end
        end
    end

    // Select the granted channel's request fields for latching.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_write = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (w_grant_idx == PTR_W'(i)) begin
                w_sel_addr  = i_req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = i_req_wdata[i*DATA_W +: DATA_W];
                w_sel_write = i_req_write[i];
            end
        end
    end

    // Current write byte and the read word with the current byte merged in.
    always_comb begin
        w_wbyte      = '0;
        w_rdata_next = r_rdata;
        for (int unsigned b = 0; b < BYTES; b++) begin
            if (r_byte_cnt == CNT_W'(b)) begin
                w_wbyte                 = r_wdata[b*8 +: 8];
                w_rdata_next[b*8 +: 8]  = i_mem_read_value;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and output decode; req_ready is gated by reset because it is combinational
    // from the request inputs while the state is already forced to idle.
    always_comb begin
        w_state_next      = r_state;
        w_accept          = 1'b0;
        o_req_ready       = '0;
        o_rsp_valid       = '0;
        o_busy            = 1'b0;
        o_mem_address     = '0;
        o_mem_read        = 1'b0;
        o_mem_write       = 1'b0;
        o_mem_write_value = '0;
        unique case (r_state)
            StIdle: begin
                if (w_grant_found && i_rst_n) begin
                    w_accept     = 1'b1;
                    o_req_ready  = NUM_CH'(1) << w_grant_idx;
                    w_state_next = StAccess;
                end
            end
            StAccess: begin
                o_busy            = 1'b1;
                o_mem_address     = r_addr + ADDR_W'(r_byte_cnt);
                o_mem_read        = !r_write;
                o_mem_write       = r_write;
                o_mem_write_value = w_wbyte;
                if (i_mem_ready && w_last_byte) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                o_busy       = 1'b1;
                o_rsp_valid  = NUM_CH'(1) << r_grant;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Request latching, byte sequencing, read assembly and pointer advance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr      <= '0;
            r_grant    <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_write    <= 1'b0;
            r_byte_cnt <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_accept) begin
                r_grant    <= w_grant_idx;
                r_addr     <= w_sel_addr;
                r_wdata    <= w_sel_wdata;
                r_write    <= w_sel_write;
                r_byte_cnt <= '0;
            end
            if (r_state == StAccess && i_mem_ready) begin
                if (!r_write) begin
                    r_rdata <= w_rdata_next;
                end
                r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end
            if (r_state == StDone) begin
                r_ptr <= (r_grant == PTR_W'(NUM_CH - 1)) ? '0 : r_grant + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: expected responses are queued when a request is
// driven and popped when rsp_valid appears; a byte-level memory model logs each access.
module tb_mem_access_ctrl;

    localparam int ADDR_W = 16;
    localparam int NUM_CH = 2;
    localparam int BYTES  = 4;

    typedef struct {
        int          ch;
        logic [31:0] rdata;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_CH-1:0]         req_valid = '0;
    logic [NUM_CH-1:0]         req_write = '0;
    logic [NUM_CH*ADDR_W-1:0]  req_addr = '0;
    logic [NUM_CH*8*BYTES-1:0] req_wdata = '0;
    logic [NUM_CH-1:0]         req_ready;
    logic [NUM_CH-1:0]         rsp_valid;
    logic [8*BYTES-1:0]        rsp_rdata;
    logic                      busy;
    logic [ADDR_W-1:0]         mem_address;
    logic                      mem_read;
    logic                      mem_write;
    logic [7:0]                mem_write_value;
    logic [7:0]                mem_read_value;
    logic                      mem_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .ADDR_W (ADDR_W),
        .NUM_CH (NUM_CH),
        .BYTES  (BYTES)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_req_valid       (req_valid),
        .i_req_write       (req_write),
        .i_req_addr        (req_addr),
        .i_req_wdata       (req_wdata),
        .o_req_ready       (req_ready),
        .o_rsp_valid       (rsp_valid),
        .o_rsp_rdata       (rsp_rdata),
        .o_busy            (busy),
        .o_mem_address     (mem_address),
        .o_mem_read        (mem_read),
        .o_mem_write       (mem_write),
        .o_mem_write_value (mem_write_value),
        .i_mem_read_value  (mem_read_value),
        .i_mem_ready       (mem_ready)
    );

    // Memory model: read contents from rd_mem, ready after ready_wait stall cycles per byte.
    logic [7:0] rd_mem [0:65535];
    int ready_wait = 0;
    int wcnt = 0;

    assign mem_read_value = rd_mem[mem_address];
    assign mem_ready = (mem_read || mem_write) && (wcnt >= ready_wait);

    always @(posedge clk) begin
        if ((mem_read || mem_write) && !mem_ready) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    // Monitor, sampled mid-cycle: grants, responses, completed bytes, hold/stability.
    int both_hi = 0, unstable = 0, rsp0_cnt = 0, rsp1_cnt = 0, hold = 0;
    logic        prev_pend = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [7:0]  prev_wval = '0;
    logic        prev_wr = 1'b0;
    logic [15:0] baddr_q[$];
    logic [7:0]  bval_q[$];
    int          hold_q[$];
    logic [1:0]  grant_q[$];

    always @(negedge clk) begin
        #3;
        if (mem_read && mem_write) both_hi <= both_hi + 1;
        if (req_ready != '0) grant_q.push_back(req_ready);
        if (rsp_valid[0]) rsp0_cnt <= rsp0_cnt + 1;
        if (rsp_valid[1]) rsp1_cnt <= rsp1_cnt + 1;
        if (mem_read || mem_write) begin
            if (prev_pend && (mem_address != prev_addr || mem_write_value != prev_wval ||
                              mem_write != prev_wr))
                unstable <= unstable + 1;
            if (mem_ready) begin
                baddr_q.push_back(mem_address);
                bval_q.push_back(mem_write_value);
                hold_q.push_back(hold + 1);
                hold      <= 0;
                prev_pend <= 1'b0;
            end else begin
                hold      <= hold + 1;
                prev_pend <= 1'b1;
            end
            prev_addr <= mem_address;
            prev_wval <= mem_write_value;
            prev_wr   <= mem_write;
        end else begin
            hold      <= 0;
            prev_pend <= 1'b0;
        end
    end

    // Present a request on one channel until req_ready, then withdraw it at cycle 1.
    task automatic accept(input int ch, input logic wr, input logic [15:0] addr,
                          input logic [31:0] wd, output logic got);
        got = 1'b0;
        req_valid[ch] = 1'b1;
        req_write[ch] = wr;
        req_addr[ch*16 +: 16] = addr;
        req_wdata[ch*32 +: 32] = wd;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req_ready[ch]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        req_valid[ch] = 1'b0;
    endtask

    task automatic clear_logs();
        baddr_q.delete();
        bval_q.delete();
        hold_q.delete();
        grant_q.delete();
    endtask

    task automatic test_reset();
        logic [63:0] obs;
        rst_n = 1'b0;
        req_valid = 2'b11;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_req_ready: got %b want 00", req_ready);
        end
        obs = {rsp_valid, busy, mem_read, mem_write, mem_write_value, mem_address, rsp_rdata};
        n_cmp++;
        if (obs !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", obs);
        end
        req_valid = 2'b00;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_read();
        logic got;
        exp_t e;
        rd_mem[16'h0100] = 8'h11; rd_mem[16'h0101] = 8'h22;
        rd_mem[16'h0102] = 8'h33; rd_mem[16'h0103] = 8'h44;
        ready_wait = 0;
        exp_q.push_back('{0, 32'h44332211});
        accept(0, 1'b0, 16'h0100, 32'h0, got);
        n_cmp++;
        if (got !== 1'b1) begin
            n_fail++;
            $display("FAIL read_accept: got %b want 1", got);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({mem_read, mem_write, mem_address} !== {1'b1, 1'b0, 16'h0100 + 16'(k)}) begin
                n_fail++;
                $display("FAIL read_addr_cycle%0d: got rd=%b wr=%b addr=%h want rd=1 wr=0 addr=%h",
                         k + 1, mem_read, mem_write, mem_address, 16'h0100 + 16'(k));
            end
            @(negedge clk);
        end
        n_cmp++;
        if (rsp_valid !== 2'b01) begin
            n_fail++;
            $display("FAIL read_rsp_valid_cycle5: got %b want 01", rsp_valid);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (rsp_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL read_rdata: got %h want %h", rsp_rdata, e.rdata);
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, rsp_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL read_back_to_idle: got busy=%b rsp=%b want 0/00", busy, rsp_valid);
        end
    endtask

    task automatic test_write();
        logic got;
        exp_t e;
        int n;
        int base1;
        logic [31:0] wd;
        wd = 32'hA1B2C3D4;
        ready_wait = 2;
        clear_logs();
        base1 = rsp1_cnt;
        exp_q.push_back('{1, 32'h44332211});
        accept(1, 1'b1, 16'h0200, wd, got);
        n = 0;
        while (rsp_valid == 2'b00 && n < 60) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (rsp_valid !== 2'b10) begin
            n_fail++;
            $display("FAIL write_rsp_valid: got %b want 10", rsp_valid);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (rsp_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL write_rdata_unchanged: got %h want %h", rsp_rdata, e.rdata);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (baddr_q.size() !== 4) begin
            n_fail++;
            $display("FAIL write_byte_count: got %0d want 4", baddr_q.size());
        end
        for (int k = 0; k < 4 && k < baddr_q.size(); k++) begin
            n_cmp++;
            if ({baddr_q[k], bval_q[k], hold_q[k]} !== {16'h0200 + 16'(k), wd[k*8 +: 8], 32'd3}) begin
                n_fail++;
                $display("FAIL write_byte%0d: got addr=%h val=%h hold=%0d want addr=%h val=%h hold=3",
                         k, baddr_q[k], bval_q[k], hold_q[k], 16'h0200 + 16'(k), wd[k*8 +: 8]);
            end
        end
        n_cmp++;
        if (unstable !== 0) begin
            n_fail++;
            $display("FAIL write_stable: got %0d unstable cycles want 0", unstable);
        end
        n_cmp++;
        if (rsp1_cnt - base1 !== 1) begin
            n_fail++;
            $display("FAIL write_single_rsp: got %0d want 1", rsp1_cnt - base1);
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int nrsp;
        logic [1:0] want;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rd_mem[16'h0300 + 16'(k)] = 8'(k + 1);
            rd_mem[16'h0400 + 16'(k)] = 8'(k + 5);
        end
        ready_wait = 0;
        clear_logs();
        exp_q.push_back('{0, 32'h04030201});
        exp_q.push_back('{1, 32'h08070605});
        exp_q.push_back('{0, 32'h04030201});
        exp_q.push_back('{1, 32'h08070605});
        req_write = 2'b00;
        req_addr = {16'h0400, 16'h0300};
        req_valid = 2'b11;
        nrsp = 0;
        for (int c = 0; c < 80 && nrsp < 4; c++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) begin
                e = exp_q.pop_front();
                want = 2'(1 << e.ch);
                nrsp++;
                if (nrsp == 4) req_valid = 2'b00;
                n_cmp++;
                if ({rsp_valid, rsp_rdata} !== {want, e.rdata}) begin
                    n_fail++;
                    $display("FAIL rr_rsp%0d: got rsp=%b data=%h want rsp=%b data=%h",
                             nrsp, rsp_valid, rsp_rdata, want, e.rdata);
                end
            end
        end
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (grant_q.size() !== 4) begin
            n_fail++;
            $display("FAIL rr_grant_count: got %0d want 4", grant_q.size());
        end
        for (int k = 0; k < 4 && k < grant_q.size(); k++) begin
            want = (k % 2 == 0) ? 2'b01 : 2'b10;
            n_cmp++;
            if (grant_q[k] !== want) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got %b want %b", k, grant_q[k], want);
            end
        end
    endtask

    task automatic test_wrap();
        logic got;
        exp_t e;
        int n;
        logic [15:0] wa [4];
        wa = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        rd_mem[16'hFFFE] = 8'hAA; rd_mem[16'hFFFF] = 8'hBB;
        rd_mem[16'h0000] = 8'hCC; rd_mem[16'h0001] = 8'hDD;
        ready_wait = 0;
        clear_logs();
        exp_q.push_back('{0, 32'hDDCCBBAA});
        accept(0, 1'b0, 16'hFFFE, 32'h0, got);
        n = 0;
        while (rsp_valid == 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({rsp_valid, rsp_rdata} !== {2'b01, e.rdata}) begin
            n_fail++;
            $display("FAIL wrap_rsp: got rsp=%b data=%h want rsp=01 data=%h",
                     rsp_valid, rsp_rdata, e.rdata);
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (k >= baddr_q.size() || baddr_q[k] !== wa[k]) begin
                n_fail++;
                $display("FAIL wrap_addr%0d: got %h want %h", k,
                         (k < baddr_q.size()) ? baddr_q[k] : 16'hxxxx, wa[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic got;
        exp_t e;
        int n;
        int base;
        logic [63:0] obs;
        for (int k = 0; k < 4; k++) begin
            rd_mem[16'h0500 + 16'(k)] = 8'h50 + 8'(k);
            rd_mem[16'h0600 + 16'(k)] = 8'h6D + 8'(k * 15);
        end
        ready_wait = 0;
        base = rsp0_cnt + rsp1_cnt;
        accept(1, 1'b0, 16'h0500, 32'h0, got);
        @(negedge clk);
        n_cmp++;
        if ({mem_read, mem_address} !== {1'b1, 16'h0501}) begin
            n_fail++;
            $display("FAIL rstmid_byte2: got rd=%b addr=%h want rd=1 addr=0501", mem_read, mem_address);
        end
        #1 rst_n = 1'b0;
        #1;
        obs = {rsp_valid, busy, mem_read, mem_write, mem_write_value, mem_address, rsp_rdata};
        n_cmp++;
        if (obs !== 64'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got %h want 0", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rsp0_cnt + rsp1_cnt !== base) begin
            n_fail++;
            $display("FAIL rstmid_no_rsp: got %0d responses want 0", rsp0_cnt + rsp1_cnt - base);
        end
        exp_q.push_back('{0, 32'h9A8B7C6D});
        req_write = 2'b00;
        req_addr = {16'h0500, 16'h0600};
        req_valid = 2'b11;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL rstmid_grant_ch0: got %b want 01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        n = 0;
        while (rsp_valid == 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({rsp_valid, rsp_rdata} !== {2'b01, e.rdata}) begin
            n_fail++;
            $display("FAIL rstmid_complete: got rsp=%b data=%h want rsp=01 data=%h",
                     rsp_valid, rsp_rdata, e.rdata);
        end
    endtask

    task automatic test_withdraw();
        logic got;
        exp_t e;
        int n;
        int base0;
        logic [31:0] wd;
        wd = 32'h55667788;
        ready_wait = 1;
        repeat (2) @(negedge clk);
        clear_logs();
        base0 = rsp0_cnt;
        exp_q.push_back('{1, 32'h9A8B7C6D});
        accept(1, 1'b1, 16'h0700, wd, got);
        // Disturb ch1 inputs after acceptance and flash a one-cycle ch0 request.
        req_addr[16 +: 16] = 16'h7777;
        req_wdata[32 +: 32] = 32'h0;
        req_write[1] = 1'b0;
        req_write[0] = 1'b0;
        req_addr[0 +: 16] = 16'h0100;
        req_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        n = 0;
        while (rsp_valid == 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({rsp_valid, rsp_rdata} !== {2'b10, e.rdata}) begin
            n_fail++;
            $display("FAIL withdraw_rsp: got rsp=%b data=%h want rsp=10 data=%h",
                     rsp_valid, rsp_rdata, e.rdata);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (grant_q.size() !== 1 || grant_q[0] !== 2'b10) begin
            n_fail++;
            $display("FAIL withdraw_grants: got %0d grants first=%b want 1 grant 10",
                     grant_q.size(), (grant_q.size() > 0) ? grant_q[0] : 2'bxx);
        end
        n_cmp++;
        if (rsp0_cnt !== base0) begin
            n_fail++;
            $display("FAIL withdraw_no_rsp0: got %0d want 0", rsp0_cnt - base0);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (k >= baddr_q.size() || {baddr_q[k], bval_q[k]} !== {16'h0700 + 16'(k), wd[k*8 +: 8]}) begin
                n_fail++;
                $display("FAIL withdraw_byte%0d: got %0d bytes logged want addr=%h val=%h",
                         k, baddr_q.size(), 16'h0700 + 16'(k), wd[k*8 +: 8]);
            end
        end
        n_cmp++;
        if (both_hi !== 0) begin
            n_fail++;
            $display("FAIL strobe_exclusive: got %0d cycles with both strobes want 0", both_hi);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) rd_mem[a] = 8'h00;
        test_reset();
        test_read();
        test_write();
        test_round_robin();
        test_wrap();
        test_reset_mid();
        test_withdraw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1);
    end

endmodule
